// File: rtl/int_priority_ctrl.sv
// rtl/int_priority_ctrl.sv - four-source edge-captured, masked, prioritised interrupt controller
// Optional nesting (higher priority preempts a running handler) is enabled by INT_NESTED_EN.
module int_priority_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq,
    input  logic       mask_we,
    input  logic [3:0] mask_din,
    input  logic       gie_we,
    input  logic       gie_din,
    input  logic       int_ack,
    input  logic       eret,
    output logic       int_req,
    output logic [1:0] int_code,
    output logic [3:0] pending,
    output logic [3:0] in_service,
    output logic [3:0] mask,
    output logic       gie
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t     state;
    logic [3:0] irq_d;
    logic [3:0] irq_rise;
    logic [3:0] allowed;
    logic [3:0] eligible;
    logic [3:0] ack_set;
    logic [3:0] eret_clr;
    logic [1:0] winner;

    always_comb begin
        irq_rise = irq & ~irq_d;

`ifdef INT_NESTED_EN
        // Only sources strictly above the innermost active handler may interrupt it.
        casez (in_service)
            4'b???1: allowed = 4'b0000;
            4'b??10: allowed = 4'b0001;
            4'b?100: allowed = 4'b0011;
            4'b1000: allowed = 4'b0111;
            default: allowed = 4'b1111;
        endcase
`else
        allowed = (in_service == 4'b0000) ? 4'b1111 : 4'b0000;
`endif

        eligible = pending & ~mask & allowed & {4{gie}};

        if (eligible[0])      winner = 2'd0;
        else if (eligible[1]) winner = 2'd1;
        else if (eligible[2]) winner = 2'd2;
        else                  winner = 2'd3;

        ack_set  = (state == REQ && int_ack) ? (4'b0001 << int_code) : 4'b0000;
        // Innermost handler is the lowest set bit: x & -x isolates it.
        eret_clr = eret ? (in_service & (~in_service + 4'd1)) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_code   <= 2'b00;
            pending    <= 4'b0000;
            in_service <= 4'b0000;
            mask       <= 4'b0000;
            gie        <= 1'b0;
            irq_d      <= 4'b0000;
        end else begin
            irq_d      <= irq;
            // A new edge on the acknowledged source wins over the ack clear.
            pending    <= (pending & ~ack_set) | irq_rise;
            in_service <= (in_service & ~eret_clr) | ack_set;
            if (mask_we) mask <= mask_din;
            if (gie_we)  gie  <= gie_din;

            case (state)
                IDLE: begin
                    if (eligible != 4'b0000 && !eret) begin
                        state    <= REQ;
                        int_req  <= 1'b1;
                        int_code <= winner;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_priority_ctrl.sv
// tb/tb_int_priority_ctrl.sv - directed and randomized checks of int_priority_ctrl against a behavioural model
module tb_int_priority_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq = 4'b0000;
    logic       mask_we = 1'b0;
    logic [3:0] mask_din = 4'b0000;
    logic       gie_we = 1'b0;
    logic       gie_din = 1'b0;
    logic       int_ack = 1'b0;
    logic       eret = 1'b0;
    logic       int_req;
    logic [1:0] int_code;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] mask;
    logic       gie;

    int checks = 0;
    int failures = 0;

    bit       m_req;
    bit [1:0] m_code;
    bit [3:0] m_pend;
    bit [3:0] m_is;
    bit [3:0] m_mask;
    bit       m_gie;
    bit [3:0] m_irqd;

    int_priority_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .gie_we     (gie_we),
        .gie_din    (gie_din),
        .int_ack    (int_ack),
        .eret       (eret),
        .int_req    (int_req),
        .int_code   (int_code),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask),
        .gie        (gie)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the rules directly, then clock the DUT and compare.
    task automatic tick();
        int       lis;
        bit [3:0] elig;
        int       win;
        bit [3:0] n_pend;
        bit [3:0] n_is;
        bit       ok;
        if (rst) begin
            m_req = 0; m_code = 0; m_pend = 0; m_is = 0; m_mask = 0; m_gie = 0; m_irqd = 0;
        end else begin
            lis = 4;
            for (int i = 3; i >= 0; i--) if (m_is[i]) lis = i;
            elig = 0;
            win = -1;
            for (int i = 0; i < 4; i++) begin
`ifdef INT_NESTED_EN
                ok = (i < lis);
`else
                ok = (m_is == 0);
`endif
                if (m_pend[i] && !m_mask[i] && m_gie && ok) begin
                    elig[i] = 1;
                    if (win < 0) win = i;
                end
            end
            n_pend = m_pend;
            n_is = m_is;
            if (eret && lis < 4) n_is[lis] = 0;
            if (m_req && int_ack) begin
                n_pend[m_code] = 0;
                n_is[m_code] = 1;
            end
            for (int i = 0; i < 4; i++) if (irq[i] && !m_irqd[i]) n_pend[i] = 1;
            if (!m_req) begin
                if (elig != 0 && !eret) begin
                    m_req = 1;
                    m_code = win[1:0];
                end
            end else if (int_ack) begin
                m_req = 0;
            end
            m_pend = n_pend;
            m_is = n_is;
            m_irqd = irq;
            if (mask_we) m_mask = mask_din;
            if (gie_we) m_gie = gie_din;
        end
        @(posedge clk);
        #1;
        chk("int_req", {3'b0, int_req}, {3'b0, m_req});
        chk("int_code", {2'b0, int_code}, {2'b0, m_code});
        chk("pending", pending, m_pend);
        chk("in_service", in_service, m_is);
        chk("mask", mask, m_mask);
        chk("gie", {3'b0, gie}, {3'b0, m_gie});
        rst = 0; mask_we = 0; gie_we = 0; int_ack = 0; eret = 0;
    endtask

    initial begin
        // Reset
        rst = 1; tick();
        chk("rst_req", {3'b0, int_req}, 4'h0);
        chk("rst_pend", pending, 4'h0);

        // Single source 2
        gie_we = 1; gie_din = 1; tick();
        irq = 4'b0100; tick();
        chk("t1_pend", pending, 4'b0100);
        irq = 4'b0000; tick();
        chk("t1_req", {3'b0, int_req}, 4'h1);
        chk("t1_code", {2'b0, int_code}, 4'h2);
        int_ack = 1; tick();
        chk("t1_ack_pend", pending, 4'b0000);
        chk("t1_ack_is", in_service, 4'b0100);
        chk("t1_ack_req", {3'b0, int_req}, 4'h0);
        eret = 1; tick();
        chk("t1_eret_is", in_service, 4'b0000);

        // Simultaneous sources 1 and 3
        irq = 4'b1010; tick();
        irq = 4'b0000; tick();
        chk("t2_code_first", {2'b0, int_code}, 4'h1);
        int_ack = 1; tick();
        eret = 1; tick();
        tick();
        chk("t2_req_second", {3'b0, int_req}, 4'h1);
        chk("t2_code_second", {2'b0, int_code}, 4'h3);
        int_ack = 1; tick();
        eret = 1; tick();

        // Masked source released by mask write
        mask_we = 1; mask_din = 4'b0001; tick();
        irq = 4'b0001; tick();
        irq = 4'b0000; tick();
        tick();
        chk("t3_masked_req", {3'b0, int_req}, 4'h0);
        chk("t3_masked_pend", pending, 4'b0001);
        mask_we = 1; mask_din = 4'b0000; tick();
        chk("t3_not_yet", {3'b0, int_req}, 4'h0);
        tick();
        chk("t3_req", {3'b0, int_req}, 4'h1);
        chk("t3_code", {2'b0, int_code}, 4'h0);
        int_ack = 1; tick();
        eret = 1; tick();

        // Source 0 arrives while source 2 is in service
        irq = 4'b0100; tick();
        irq = 4'b0000; tick();
        int_ack = 1; tick();
        irq = 4'b0001; tick();
        irq = 4'b0000; tick();
`ifdef INT_NESTED_EN
        chk("t4_preempt_req", {3'b0, int_req}, 4'h1);
        chk("t4_preempt_code", {2'b0, int_code}, 4'h0);
        int_ack = 1; tick();
        chk("t4_nested_is", in_service, 4'b0101);
        eret = 1; tick();
        eret = 1; tick();
`else
        chk("t4_blocked_req", {3'b0, int_req}, 4'h0);
        eret = 1; tick();
        tick();
        chk("t4_after_eret_req", {3'b0, int_req}, 4'h1);
        chk("t4_after_eret_code", {2'b0, int_code}, 4'h0);
        int_ack = 1; tick();
        eret = 1; tick();
`endif

        // Same-cycle ack and new edge on source 3
        irq = 4'b1000; tick();
        irq = 4'b0000; tick();
        chk("t5_code", {2'b0, int_code}, 4'h3);
        irq = 4'b1000; int_ack = 1; tick();
        chk("t5_pend", pending, 4'b1000);
        chk("t5_is", in_service, 4'b1000);
        irq = 4'b0000; tick();
        tick();
        chk("t5_no_req", {3'b0, int_req}, 4'h0);
        eret = 1; tick();
        tick();
        chk("t5_req_after_eret", {3'b0, int_req}, 4'h1);
        int_ack = 1; tick();
        eret = 1; tick();

        // Reset while a request is presented
        irq = 4'b0110; tick();
        irq = 4'b0000; tick();
        chk("t6_pre_pend", pending, 4'b0110);
        rst = 1; tick();
        chk("t6_req", {3'b0, int_req}, 4'h0);
        chk("t6_pend", pending, 4'h0);
        chk("t6_gie", {3'b0, gie}, 4'h0);

        // Randomized traffic against the model
        gie_we = 1; gie_din = 1; tick();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) irq = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin mask_we = 1; mask_din = 4'($urandom) & 4'($urandom); end
            if ($urandom_range(0, 15) == 0) begin gie_we = 1; gie_din = ($urandom_range(0, 3) != 0); end
            int_ack = int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            eret = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
